// File: rtl/m_unit_iterative.sv
// Iterative RV32M/RV64M coprocessor on the PCPI bus: shift-add multiplier and
// restoring divider sharing one IDLE/CALC/DONE controller.
module m_unit_iterative #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4,
    parameter int DIV_STEP = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            pcpi_valid,
    input  logic [31:0]     pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic            pcpi_busy,
    output logic            pcpi_ready
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] MUL_CNT = CW'(XLEN / MUL_STEP);
    localparam logic [CW-1:0] DIV_CNT = CW'(XLEN / DIV_STEP);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state;
    state_t state_next;

    // Handshake: an instruction is taken when pcpi_valid is high in IDLE and it
    // decodes as an M op; the core must hold pcpi_valid high until pcpi_ready,
    // and dropping it during CALC cancels the operation without a ready strobe.
    logic       match;
    logic       accept;
    logic [2:0] funct3;
    logic       unused_insn;

    assign match       = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
    assign funct3      = pcpi_insn[14:12];
    assign accept      = (state == IDLE) && pcpi_valid && match;
    assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    // Operand preparation at accept
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    assign rs1_neg = pcpi_rs1[XLEN-1];
    assign rs2_neg = pcpi_rs2[XLEN-1];
    assign abs1    = rs1_neg ? -pcpi_rs1 : pcpi_rs1;
    assign abs2    = rs2_neg ? -pcpi_rs2 : pcpi_rs2;

    always_comb begin
        op_a  = pcpi_rs1;
        op_b  = pcpi_rs2;
        neg_q = 1'b0;
        neg_r = 1'b0;
        case (funct3)
            3'b001: begin
                op_a  = abs1;
                op_b  = abs2;
                neg_q = rs1_neg ^ rs2_neg;
            end
            3'b010: begin
                op_a  = abs1;
                neg_q = rs1_neg;
            end
            3'b100, 3'b110: begin
                op_a  = abs1;
                op_b  = abs2;
                neg_q = rs1_neg ^ rs2_neg;
                neg_r = rs1_neg;
            end
            default: begin
                op_a  = pcpi_rs1;
                op_b  = pcpi_rs2;
            end
        endcase
    end

    // Divide by zero and signed overflow are answered without iterating
    assign div_zero    = (pcpi_rs2 == '0);
    assign div_ovf     = !funct3[0] && (pcpi_rs1 == MIN_NEG) && (pcpi_rs2 == '1);
    assign special     = funct3[2] && (div_zero || div_ovf);
    assign special_res = div_zero ? (funct3[1] ? pcpi_rs1 : '1)
                                  : (funct3[1] ? '0 : pcpi_rs1);

    // Latched operation context and datapath registers
    logic [2:0]        op;
    logic              sgn_q;
    logic              sgn_r;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   dvd;
    logic [XLEN-1:0]   dsr;

    logic [2*XLEN-1:0] acc_n;
    logic [2*XLEN-1:0] mcand_n;
    logic [XLEN-1:0]   mplier_n;

    always_comb begin
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_n[0]) begin
                acc_n = acc_n + mcand_n;
            end
            mcand_n  = mcand_n << 1;
            mplier_n = mplier_n >> 1;
        end
    end

    // Quotient bits shift into the low end of the dividend register
    logic [XLEN-1:0] rem_n;
    logic [XLEN-1:0] dvd_n;
    logic [XLEN:0]   trial;

    always_comb begin
        rem_n = rem;
        dvd_n = dvd;
        trial = '0;
        for (int i = 0; i < DIV_STEP; i++) begin
            trial = {rem_n, dvd_n[XLEN-1]};
            dvd_n = dvd_n << 1;
            if (trial >= {1'b0, dsr}) begin
                trial    = trial - {1'b0, dsr};
                dvd_n[0] = 1'b1;
            end
            rem_n = trial[XLEN-1:0];
        end
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   calc_res;

    always_comb begin
        prod_fix = sgn_q ? -acc_n : acc_n;
        mul_res  = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        quo_fix  = sgn_q ? -dvd_n : dvd_n;
        rem_fix  = sgn_r ? -rem_n : rem_n;
        calc_res = op[2] ? (op[1] ? rem_fix : quo_fix) : mul_res;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (!pcpi_valid) begin
                    state_next = IDLE;
                end else if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pcpi_ready = (state == DONE);
        pcpi_wr    = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pcpi_rd   <= '0;
            pcpi_busy <= 1'b0;
            op        <= '0;
            sgn_q     <= 1'b0;
            sgn_r     <= 1'b0;
            count     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            dvd       <= '0;
            dsr       <= '0;
        end else begin
            pcpi_busy <= (state_next != IDLE);
            if (accept) begin
                op     <= funct3;
                sgn_q  <= neg_q;
                sgn_r  <= neg_r;
                count  <= funct3[2] ? DIV_CNT : MUL_CNT;
                acc    <= '0;
                mcand  <= {{XLEN{1'b0}}, op_a};
                mplier <= op_b;
                rem    <= '0;
                dvd    <= op_a;
                dsr    <= op_b;
                if (special) begin
                    pcpi_rd <= special_res;
                end
            end else if (state == CALC && pcpi_valid) begin
                count <= count - CW'(1);
                if (op[2]) begin
                    rem <= rem_n;
                    dvd <= dvd_n;
                end else begin
                    acc    <= acc_n;
                    mcand  <= mcand_n;
                    mplier <= mplier_n;
                end
                if (count == CW'(1)) begin
                    pcpi_rd <= calc_res;
                end
            end
        end
    end

endmodule
